status_reg: RTL and testbench
=============================

# status_reg

Processor status (P) register for the AK6502 core. It sits directly upstream and downstream of the ALU: it drives the ALU's `flags_i` and captures the ALU's `flags_o` whenever the ALU asserts `p_load`. It also handles:
- flag set/clear instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED);
- PLP loads and PHP/BRK/IRQ push values;
- the hidden-carry bit used for address arithmetic;
- IRQ/NMI recognition with 6502 I-flag latency.

## Interface
Parameters:
- BCD_EN, 1, when 0 the D flag is held at 0 (SED and PLP cannot set it).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  cycle enable; when 0, no architectural flag state changes (the interrupt synchronisers still run).
- flags_o  out  8  to ALU flags_i: {N,V,HC,1'b0,D,I,Z,C}.
- alu_flags  in  8  from ALU flags_o.
- p_load  in  1  from ALU; load N,V,Z,C,HC from alu_flags.
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- pull_load  in  1  PLP/RTI: load N,V,D,I,Z,C from din.
- din  in  8  data bus value for pull_load.
- hc_clr  in  1  clear hidden carry.
- int_enter  in  1  interrupt/BRK entry; set I.
- push_brk  in  1  selects the B bit in push_val.
- push_val  out  8  {N,V,1,push_brk,D,I,Z,C}, combinational from the register.
- sync  in  1  instruction-boundary strobe (opcode fetch cycle).
- irq_n  in  1  level-sensitive IRQ, asynchronous.
- nmi_n  in  1  edge-sensitive NMI, asynchronous.
- nmi_ack  in  1  sequencer has taken the NMI.
- irq_req  out  1  IRQ pending and not masked.
- nmi_req  out  1  NMI edge pending.

## Operation
- Storage: C,Z,I,D,V,N and HC (the hidden carry, ALU bit 5). The B bit is not stored; flags_o[4] is always 0.
- Writes apply only when ce=1. Flag write priority within one cycle: pull_load > flag_op != 0 > p_load.
  - pull_load: C,Z,I,D,V,N <= din[0,1,2,3,6,7]; HC <= 0; din[5:4] ignored.
  - flag_op: modifies only its own bit.
  - p_load: C,Z,V,N,HC <= alu_flags[0,1,6,7,5]; I and D are never taken from alu_flags.
- Operations that apply in addition to the priority chain:
  - hc_clr: HC <= 0. It overrides a p_load HC value in the same cycle.
  - int_enter: I <= 1. It overrides pull_load or CLI in the same cycle.
- BCD_EN=0: D is held at 0, and SED is a no-op.
- I-flag latency: i_snap <= I on each cycle with sync=1 and ce=1. IRQ masking uses i_snap, not I, so CLI/SEI/PLP take effect at the following instruction boundary.
- IRQ path: irq_n goes through a 2-flop synchroniser to give irq_s. irq_req = ~irq_s & ~i_snap (registered).
- NMI path:
  - nmi_n goes through a 2-flop synchroniser, then a falling-edge detector sets nmi_pend.
  - nmi_ack clears nmi_pend.
  - If an edge and nmi_ack occur in the same cycle, the set wins.
  - nmi_req = nmi_pend.
  - The NMI path runs regardless of ce and I.

## Timing
- Reset values:
  - flags_o = 8'h04 (I=1, all else 0).
  - push_val = 8'h24, with push_brk=0.
  - i_snap = 1.
  - irq_req = 0, nmi_req = 0.
  - Synchroniser flops = 1 (inactive).
  - Reset mid-operation aborts any pending NMI.
- Flag writes are visible on flags_o one cycle after the enabling edge. The ALU may compute from flags_o and assert p_load in the same cycle, because the path is combinational into the register.
- push_val follows flags_o combinationally, and follows push_brk with zero latency.
- IRQ latency from an irq_n fall to irq_req=1 is 3 clk when i_snap=0: 2 synchroniser cycles plus 1 output register.
- NMI latency from an nmi_n fall to nmi_req=1 is 3 clk. nmi_req drops the cycle after nmi_ack.
- An NMI pulse held low for fewer than 2 clk may be missed. nmi_n must be held low for at least 2 clk.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle, then release -> flags_o=8'h04, push_val=8'h24, irq_req=0, nmi_req=0.
- ALU load with a conflict: p_load=1, alu_flags=8'hE3, flag_op=SEI, hc_clr=1 -> next cycle flags_o=8'hC7.
  - N,V,Z,C come from the ALU.
  - I=1 from SEI.
  - HC=0 from hc_clr.
- PLP with interrupt entry: din=8'hFF, pull_load=1, int_enter=1 -> flags_o=8'hCF (HC=0, bit 4=0). With push_brk=1, push_val=8'hFF. Repeat with BCD_EN=0 -> flags_o=8'hC7.
- CLI latency: I=1, irq_n held low.
  - Issue CLI; no sync follows -> irq_req stays 0.
  - Pulse sync -> irq_req=1 on the next clk.
  - Then SEI plus sync -> irq_req=0 one cycle after that sync.
- NMI edge:
  - nmi_n falls with I=1 -> nmi_req=1 after 3 clk.
  - nmi_ack=1 -> nmi_req=0 on the next clk.
  - A second falling edge on the same cycle as nmi_ack keeps nmi_req=1.
- ce gating: ce=0 with flag_op=SEC, p_load=1, pull_load=1 -> flags_o unchanged. Synchronisers still advance, so nmi_req still rises.

Source files
------------

// File: rtl/status_reg_if.sv
// Bus between the AK6502 sequencer/ALU and the processor status register.
interface status_reg_if;
  localparam int unsigned FLAG_W = 8;
  localparam int unsigned OP_W   = 3;

  logic              ce;
  logic [FLAG_W-1:0] flags_o;
  logic [FLAG_W-1:0] alu_flags;
  logic              p_load;
  logic [OP_W-1:0]   flag_op;
  logic              pull_load;
  logic [FLAG_W-1:0] din;
  logic              hc_clr;
  logic              int_enter;
  logic              push_brk;
  logic [FLAG_W-1:0] push_val;
  logic              sync;
  logic              irq_n;
  logic              nmi_n;
  logic              nmi_ack;
  logic              irq_req;
  logic              nmi_req;

  modport master (
    output ce, alu_flags, p_load, flag_op, pull_load, din, hc_clr,
           int_enter, push_brk, sync, irq_n, nmi_n, nmi_ack,
    input  flags_o, push_val, irq_req, nmi_req
  );

  modport slave (
    input  ce, alu_flags, p_load, flag_op, pull_load, din, hc_clr,
           int_enter, push_brk, sync, irq_n, nmi_n, nmi_ack,
    output flags_o, push_val, irq_req, nmi_req
  );
endinterface

// File: rtl/status_reg.sv
// AK6502 processor status register: flag storage, push/pull formatting,
// hidden carry and IRQ/NMI recognition with I-flag boundary latency.
module status_reg #(
  parameter bit BCD_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  status_reg_if.slave bus
);
  localparam int unsigned IRQ_SYNC_W = 2;
  localparam int unsigned NMI_SYNC_W = 3;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLC  = 3'd1,
    OP_SEC  = 3'd2,
    OP_CLI  = 3'd3,
    OP_SEI  = 3'd4,
    OP_CLV  = 3'd5,
    OP_CLD  = 3'd6,
    OP_SED  = 3'd7
  } flag_op_e;

  logic c_q, z_q, i_q, d_q, v_q, n_q, hc_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d, hc_d;
  logic i_snap_q, i_snap_d;
  logic [IRQ_SYNC_W-1:0] irq_sync_q;
  logic [NMI_SYNC_W-1:0] nmi_sync_q;
  logic irq_req_q, nmi_pend_q;
  logic nmi_fall;
  flag_op_e op;
  logic unused_bits;

  assign op = flag_op_e'(bus.flag_op);

  // B bit is not stored; bits the register never consumes are sunk here
  assign unused_bits = ^{bus.din[5:4], bus.alu_flags[4:2]};

  // Per-bit priority: pull_load overrides all, a flag op overrides p_load on its own bit
  always_comb begin
    c_d  = c_q;
    z_d  = z_q;
    i_d  = i_q;
    d_d  = d_q;
    v_d  = v_q;
    n_d  = n_q;
    hc_d = hc_q;
    if (bus.ce) begin
      if (bus.p_load) begin
        c_d  = bus.alu_flags[0];
        z_d  = bus.alu_flags[1];
        hc_d = bus.alu_flags[5];
        v_d  = bus.alu_flags[6];
        n_d  = bus.alu_flags[7];
      end
      case (op)
        OP_NONE: ;
        OP_CLC:  c_d = 1'b0;
        OP_SEC:  c_d = 1'b1;
        OP_CLI:  i_d = 1'b0;
        OP_SEI:  i_d = 1'b1;
        OP_CLV:  v_d = 1'b0;
        OP_CLD:  d_d = 1'b0;
        OP_SED:  d_d = 1'b1;
      endcase
      if (bus.pull_load) begin
        c_d  = bus.din[0];
        z_d  = bus.din[1];
        i_d  = bus.din[2];
        d_d  = bus.din[3];
        v_d  = bus.din[6];
        n_d  = bus.din[7];
        hc_d = 1'b0;
      end
      if (bus.hc_clr) begin
        hc_d = 1'b0;
      end
      if (bus.int_enter) begin
        i_d = 1'b1;
      end
    end
    if (!BCD_EN) begin
      d_d = 1'b0;
    end
  end

  // IRQ masking sees I only as it stood at the last instruction boundary
  always_comb begin
    i_snap_d = i_snap_q;
    if (bus.ce && bus.sync) begin
      i_snap_d = i_q;
    end
  end

  assign nmi_fall = nmi_sync_q[2] & ~nmi_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      i_q        <= 1'b1;
      d_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      hc_q       <= 1'b0;
      i_snap_q   <= 1'b1;
      irq_sync_q <= {IRQ_SYNC_W{1'b1}};
      nmi_sync_q <= {NMI_SYNC_W{1'b1}};
      irq_req_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      c_q        <= c_d;
      z_q        <= z_d;
      i_q        <= i_d;
      d_q        <= d_d;
      v_q        <= v_d;
      n_q        <= n_d;
      hc_q       <= hc_d;
      i_snap_q   <= i_snap_d;
      irq_sync_q <= {irq_sync_q[0], bus.irq_n};
      nmi_sync_q <= {nmi_sync_q[1:0], bus.nmi_n};
      irq_req_q  <= ~irq_sync_q[1] & ~i_snap_q;
      // A new edge wins over a same-cycle acknowledge
      nmi_pend_q <= nmi_fall | (nmi_pend_q & ~bus.nmi_ack);
    end
  end

  assign bus.flags_o  = {n_q, v_q, hc_q, 1'b0, d_q, i_q, z_q, c_q};
  assign bus.push_val = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
  assign bus.irq_req  = irq_req_q;
  assign bus.nmi_req  = nmi_pend_q;

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: BCD_EN=1 and BCD_EN=0 instances share stimulus.
module tb_status_reg;
  logic clk;
  logic rst_n;

  status_reg_if bus1();
  status_reg_if bus2();

  status_reg #(.BCD_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  status_reg #(.BCD_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.ce        = bus1.ce;
  assign bus2.alu_flags = bus1.alu_flags;
  assign bus2.p_load    = bus1.p_load;
  assign bus2.flag_op   = bus1.flag_op;
  assign bus2.pull_load = bus1.pull_load;
  assign bus2.din       = bus1.din;
  assign bus2.hc_clr    = bus1.hc_clr;
  assign bus2.int_enter = bus1.int_enter;
  assign bus2.push_brk  = bus1.push_brk;
  assign bus2.sync      = bus1.sync;
  assign bus2.irq_n     = bus1.irq_n;
  assign bus2.nmi_n     = bus1.nmi_n;
  assign bus2.nmi_ack   = bus1.nmi_ack;

  typedef struct {
    int         cyc;
    logic [7:0] p1;
    logic [7:0] p0;
    logic       irq;
    logic       nmi;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  // Reference model: P as an 8-bit image, plus pin histories for the interrupt paths
  bit [7:0] mp1, mp0;
  bit       m_isnap, m_irq, m_nmi;
  bit       ih[$];
  bit       nh[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] next_p(bit [7:0] p, bit bcd);
    bit [7:0] np;
    np = p;
    if (bus1.ce) begin
      if (bus1.p_load) np = (np & 8'h1C) | (bus1.alu_flags & 8'hE3);
      case (bus1.flag_op)
        3'd1: np[0] = 1'b0;
        3'd2: np[0] = 1'b1;
        3'd3: np[2] = 1'b0;
        3'd4: np[2] = 1'b1;
        3'd5: np[6] = 1'b0;
        3'd6: np[3] = 1'b0;
        3'd7: np[3] = 1'b1;
        default: ;
      endcase
      if (bus1.pull_load) np = bus1.din & 8'hCF;
      if (bus1.hc_clr)    np[5] = 1'b0;
      if (bus1.int_enter) np[2] = 1'b1;
    end
    if (!bcd) np[3] = 1'b0;
    return np;
  endfunction

  task automatic model_reset();
    mp1     = 8'h04;
    mp0     = 8'h04;
    m_isnap = 1'b1;
    m_irq   = 1'b0;
    m_nmi   = 1'b0;
    ih      = '{1'b1, 1'b1, 1'b1};
    nh      = '{1'b1, 1'b1, 1'b1};
  endtask

  task automatic push_exp(int c);
    exp_t e;
    e.cyc = c;
    e.p1  = mp1;
    e.p0  = mp0;
    e.irq = m_irq;
    e.nmi = m_nmi;
    q.push_back(e);
  endtask

  // ih/nh[k] hold the pin value driven k+1 cycles before the coming edge
  task automatic model_step();
    bit fall;
    m_irq = ~ih[1] & ~m_isnap;
    if (bus1.ce && bus1.sync) m_isnap = mp1[2];
    fall  = nh[2] & ~nh[1];
    m_nmi = fall | (m_nmi & ~bus1.nmi_ack);
    mp1   = next_p(mp1, 1'b1);
    mp0   = next_p(mp0, 1'b0);
    ih.push_front(bus1.irq_n);
    void'(ih.pop_back());
    nh.push_front(bus1.nmi_n);
    void'(nh.pop_back());
    push_exp(cyc + 1);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic idle();
    bus1.ce        = 1'b1;
    bus1.alu_flags = 8'h00;
    bus1.p_load    = 1'b0;
    bus1.flag_op   = 3'd0;
    bus1.pull_load = 1'b0;
    bus1.din       = 8'h00;
    bus1.hc_clr    = 1'b0;
    bus1.int_enter = 1'b0;
    bus1.push_brk  = 1'b0;
    bus1.sync      = 1'b0;
    bus1.nmi_ack   = 1'b0;
  endtask

  // Reset asserted mid-cycle, checked while asserted, released mid-cycle
  task automatic do_reset();
    #2;
    bus1.push_brk = 1'b0;
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    q.delete();
    model_reset();
    check8("rst_flags", bus1.flags_o, 8'h04);
    check8("rst_flags_bcd0", bus2.flags_o, 8'h04);
    check8("rst_push_val", bus1.push_val, 8'h24);
    check1("rst_irq_req", bus1.irq_req, 1'b0);
    check1("rst_nmi_req", bus1.nmi_req, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    push_exp(cyc);
    mon_en = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a new register state
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        void'(q.pop_front());
        n_checks++;
        n_fail++;
        $display("FAIL sb_order: stale expectation at cycle %0d", cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check8("sb_flags_bcd1", bus1.flags_o, e.p1);
        check8("sb_flags_bcd0", bus2.flags_o, e.p0);
        check8("sb_push_val", bus1.push_val,
               (e.p1 & 8'hCF) | 8'h20 | {3'b000, bus1.push_brk, 4'b0000});
        check1("sb_irq_req", bus1.irq_req, e.irq);
        check1("sb_irq_req_bcd0", bus2.irq_req, e.irq);
        check1("sb_nmi_req", bus1.nmi_req, e.nmi);
        check1("sb_nmi_req_bcd0", bus2.nmi_req, e.nmi);
      end
    end
  end

  initial begin
    bit [7:0] hold;
    int nmi_hold;
    rst_n = 1'b1;
    idle();
    bus1.irq_n = 1'b1;
    bus1.nmi_n = 1'b1;
    model_reset();
    do_reset();
    steps(2);

    // ALU load with SEI and hc_clr in the same cycle
    bus1.p_load = 1'b1; bus1.alu_flags = 8'hE3; bus1.flag_op = 3'd4; bus1.hc_clr = 1'b1;
    step();
    idle();
    check8("alu_conflict", bus1.flags_o, 8'hC7);

    // PLP of FF together with interrupt entry
    bus1.pull_load = 1'b1; bus1.din = 8'hFF; bus1.int_enter = 1'b1;
    step();
    idle();
    bus1.push_brk = 1'b1;
    #1;
    check8("plp_flags", bus1.flags_o, 8'hCF);
    check8("plp_push_brk", bus1.push_val, 8'hFF);
    check8("plp_flags_bcd0", bus2.flags_o, 8'hC7);
    bus1.push_brk = 1'b0;

    // CLI only unmasks IRQ at the next instruction boundary
    bus1.irq_n = 1'b0;
    steps(3);
    check1("irq_masked", bus1.irq_req, 1'b0);
    bus1.flag_op = 3'd3;
    step();
    idle();
    steps(3);
    check1("cli_no_sync", bus1.irq_req, 1'b0);
    bus1.sync = 1'b1;
    step();
    idle();
    check1("cli_sync_edge", bus1.irq_req, 1'b0);
    step();
    check1("cli_sync_next", bus1.irq_req, 1'b1);
    bus1.flag_op = 3'd4;
    step();
    idle();
    bus1.sync = 1'b1;
    step();
    idle();
    check1("sei_sync_edge", bus1.irq_req, 1'b1);
    step();
    check1("sei_sync_next", bus1.irq_req, 1'b0);
    bus1.irq_n = 1'b1;

    // NMI edge latency, set-wins over ack, then ack clears
    bus1.nmi_n = 1'b0;
    step();
    check1("nmi_lat1", bus1.nmi_req, 1'b0);
    step();
    check1("nmi_lat2", bus1.nmi_req, 1'b0);
    step();
    check1("nmi_lat3", bus1.nmi_req, 1'b1);
    bus1.nmi_n = 1'b1;
    steps(3);
    check1("nmi_rise_hold", bus1.nmi_req, 1'b1);
    bus1.nmi_n = 1'b0;
    steps(2);
    bus1.nmi_ack = 1'b1;
    step();
    check1("nmi_set_wins", bus1.nmi_req, 1'b1);
    step();
    check1("nmi_ack_clr", bus1.nmi_req, 1'b0);
    bus1.nmi_ack = 1'b0;

    // ce=0 freezes flags while the NMI path keeps running
    bus1.nmi_n = 1'b1;
    steps(3);
    hold = mp1;
    bus1.ce = 1'b0; bus1.flag_op = 3'd2; bus1.p_load = 1'b1; bus1.alu_flags = 8'hFF;
    bus1.pull_load = 1'b1; bus1.din = 8'h00; bus1.nmi_n = 1'b0;
    steps(3);
    check8("ce_gate_flags", bus1.flags_o, hold);
    check1("ce_gate_nmi", bus1.nmi_req, 1'b1);
    idle();
    bus1.nmi_ack = 1'b1;
    step();
    idle();

    // Randomized traffic
    nmi_hold = 2;
    for (int k = 0; k < 500; k++) begin
      bus1.ce        = ($urandom_range(0, 9) != 0);
      bus1.flag_op   = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      bus1.p_load    = ($urandom_range(0, 9) < 4);
      bus1.alu_flags = 8'($urandom);
      bus1.pull_load = ($urandom_range(0, 9) == 0);
      bus1.din       = 8'($urandom);
      bus1.hc_clr    = ($urandom_range(0, 9) == 0);
      bus1.int_enter = ($urandom_range(0, 19) == 0);
      bus1.push_brk  = 1'($urandom);
      bus1.sync      = ($urandom_range(0, 9) < 3);
      bus1.nmi_ack   = ($urandom_range(0, 19) < 3);
      if ($urandom_range(0, 9) == 0) bus1.irq_n = ~bus1.irq_n;
      if (nmi_hold == 0) begin
        if ($urandom_range(0, 1) == 1) bus1.nmi_n = ~bus1.nmi_n;
        nmi_hold = $urandom_range(2, 6);
      end
      nmi_hold--;
      step();
    end

    // Reset while an NMI is pending aborts it
    idle();
    bus1.nmi_n = 1'b1;
    steps(3);
    bus1.nmi_n = 1'b0;
    steps(3);
    check1("nmi_pending_pre_rst", bus1.nmi_req, 1'b1);
    bus1.nmi_n = 1'b1;
    do_reset();
    steps(4);
    check1("nmi_aborted", bus1.nmi_req, 1'b0);

    for (int k = 0; k < 100; k++) begin
      bus1.flag_op   = 3'($urandom_range(0, 7));
      bus1.p_load    = 1'($urandom);
      bus1.alu_flags = 8'($urandom);
      bus1.sync      = 1'($urandom);
      bus1.irq_n     = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    steps(3);
    #5;
    check1("sb_drained", (q.size() == 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
